// File: rtl/reorder_buffer_pkg.sv
// rob_pkg: shared widths, instruction kinds and entry layout for the reorder buffer
package rob_pkg;
  localparam int ROB_ID_W = 5;
  localparam logic [ROB_ID_W-1:0] NO_DEP = 5'd0;
  typedef enum logic [1:0] {
    KIND_REG    = 2'd0,
    KIND_STORE  = 2'd1,
    KIND_BRANCH = 2'd2
  } rob_kind_e;
  typedef struct packed {
    logic valid;
    logic done;
    logic mispredict;
    rob_kind_e kind;
    logic [4:0] rd;
    logic [31:0] value;
    logic [31:0] alt_pc;
  } rob_entry_t;
  function automatic rob_kind_e norm_kind(input logic [1:0] k);
    return (k == 2'd1) ? KIND_STORE : (k == 2'd2) ? KIND_BRANCH : KIND_REG;
  endfunction
endpackage

// File: rtl/reorder_buffer.sv
// reorder_buffer: circular in-order ROB with rename launch, result forwarding, in-order commit and mispredict flush
module reorder_buffer
  import rob_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic        clk_in,
  input  logic        rst_n_in,
  input  logic        rdy_in,
  input  logic        issue_valid,
  input  logic [1:0]  issue_kind,
  input  logic [4:0]  issue_rd,
  input  logic [31:0] issue_alt_pc,
  output logic        issue_full,
  output logic [4:0]  issue_rob_id,
  output logic        _rob_launch_ready,
  output logic [4:0]  _rob_launch_rob_id,
  output logic [4:0]  _rob_launch_register_id,
  input  logic        wb_valid,
  input  logic [4:0]  wb_rob_id,
  input  logic [31:0] wb_value,
  input  logic        wb_mispredict,
  input  logic [4:0]  query_id_1,
  input  logic [4:0]  query_id_2,
  output logic        query_ready_1,
  output logic        query_ready_2,
  output logic [31:0] query_value_1,
  output logic [31:0] query_value_2,
  output logic        _rob_commit_ready,
  output logic [4:0]  _rob_commit_rob_id,
  output logic [4:0]  _rob_commit_register_id,
  output logic [31:0] _rob_commit_value,
  output logic        commit_store,
  output logic        _clear,
  output logic [31:0] redirect_pc
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  rob_entry_t ent [DEPTH];
  rob_entry_t hd;
  logic [PW-1:0] head, tail, wb_idx, q1_idx, q2_idx;
  logic [CW-1:0] count;
  logic accept, retire, flush, wb_hit;
  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction
  assign hd = ent[head];
  assign issue_full = count == CW'(DEPTH);
  assign issue_rob_id = ROB_ID_W'(tail) + 5'd1;
  assign accept = rdy_in & issue_valid & ~issue_full & ~_clear;
  assign _rob_launch_ready = accept;
  assign _rob_launch_rob_id = issue_rob_id;
  assign _rob_launch_register_id = (norm_kind(issue_kind) == KIND_REG) ? issue_rd : 5'd0;
  // commit looks only at registered head state, so a result needs one cycle to become retirable
  assign retire = rdy_in & hd.valid & hd.done;
  assign flush = retire & (hd.kind == KIND_BRANCH) & hd.mispredict;
  assign wb_idx = PW'(wb_rob_id - 5'd1);
  assign wb_hit = rdy_in & wb_valid & ~_clear & (wb_rob_id != NO_DEP) &
                  (wb_rob_id <= ROB_ID_W'(DEPTH)) & ent[wb_idx].valid;
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      for (int i = 0; i < DEPTH; i++) ent[i] <= '0;
      head <= '0;
      tail <= '0;
      count <= '0;
      _rob_commit_ready <= 1'b0;
      _rob_commit_rob_id <= '0;
      _rob_commit_register_id <= '0;
      _rob_commit_value <= '0;
      commit_store <= 1'b0;
      _clear <= 1'b0;
      redirect_pc <= '0;
    end else if (rdy_in) begin
      _rob_commit_ready <= retire & (hd.kind == KIND_REG);
      commit_store <= retire & (hd.kind == KIND_STORE);
      _clear <= flush;
      if (retire && hd.kind == KIND_REG) begin
        _rob_commit_rob_id <= ROB_ID_W'(head) + 5'd1;
        _rob_commit_register_id <= hd.rd;
        _rob_commit_value <= hd.value;
      end
      if (flush) begin
        redirect_pc <= hd.alt_pc;
        for (int i = 0; i < DEPTH; i++) ent[i].valid <= 1'b0;
        head <= '0;
        tail <= '0;
        count <= '0;
      end else begin
        if (wb_hit) begin
          ent[wb_idx].done <= 1'b1;
          ent[wb_idx].value <= wb_value;
          ent[wb_idx].mispredict <= wb_mispredict;
        end
        if (accept)
          ent[tail] <= '{valid: 1'b1, done: 1'b0, mispredict: 1'b0, kind: norm_kind(issue_kind),
                         rd: issue_rd, value: 32'd0, alt_pc: issue_alt_pc};
        // retire after the writeback so a late result cannot revive the freed slot
        if (retire) begin
          ent[head].valid <= 1'b0;
          head <= nxt(head);
        end
        if (accept) tail <= nxt(tail);
        count <= count + CW'(accept) - CW'(retire);
      end
    end
  end
  assign q1_idx = PW'(query_id_1 - 5'd1);
  assign q2_idx = PW'(query_id_2 - 5'd1);
  always_comb begin
    query_ready_1 = 1'b0;
    query_value_1 = '0;
    if (query_id_1 != NO_DEP && query_id_1 <= ROB_ID_W'(DEPTH)) begin
      if (ent[q1_idx].valid && ent[q1_idx].done) begin
        query_ready_1 = 1'b1;
        query_value_1 = ent[q1_idx].value;
      end else if (wb_valid && wb_rob_id == query_id_1) begin
        query_ready_1 = 1'b1;
        query_value_1 = wb_value;
      end
    end
  end
  always_comb begin
    query_ready_2 = 1'b0;
    query_value_2 = '0;
    if (query_id_2 != NO_DEP && query_id_2 <= ROB_ID_W'(DEPTH)) begin
      if (ent[q2_idx].valid && ent[q2_idx].done) begin
        query_ready_2 = 1'b1;
        query_value_2 = ent[q2_idx].value;
      end else if (wb_valid && wb_rob_id == query_id_2) begin
        query_ready_2 = 1'b1;
        query_value_2 = wb_value;
      end
    end
  end
endmodule

// File: tb/tb_reorder_buffer.sv
// tb_reorder_buffer: directed and randomized checks of reorder_buffer against a queue-based model
module tb_reorder_buffer;
  localparam int DEPTH = 16;
  logic clk_in = 1'b0, rst_n_in = 1'b0, rdy_in = 1'b0;
  logic issue_valid = 1'b0, wb_valid = 1'b0, wb_mispredict = 1'b0;
  logic [1:0] issue_kind = '0;
  logic [4:0] issue_rd = '0, wb_rob_id = '0, query_id_1 = '0, query_id_2 = '0;
  logic [31:0] issue_alt_pc = '0, wb_value = '0;
  logic issue_full, launch_ready, q_rdy1, q_rdy2, commit_ready, commit_store, clear;
  logic [4:0] issue_rob_id, launch_rob_id, launch_reg_id, commit_rob_id, commit_reg_id;
  logic [31:0] q_val1, q_val2, commit_value, redirect_pc;
  int n_vec = 0, n_err = 0;

  reorder_buffer #(.DEPTH(DEPTH)) dut (
    .clk_in(clk_in), .rst_n_in(rst_n_in), .rdy_in(rdy_in),
    .issue_valid(issue_valid), .issue_kind(issue_kind), .issue_rd(issue_rd),
    .issue_alt_pc(issue_alt_pc), .issue_full(issue_full), .issue_rob_id(issue_rob_id),
    ._rob_launch_ready(launch_ready), ._rob_launch_rob_id(launch_rob_id),
    ._rob_launch_register_id(launch_reg_id),
    .wb_valid(wb_valid), .wb_rob_id(wb_rob_id), .wb_value(wb_value), .wb_mispredict(wb_mispredict),
    .query_id_1(query_id_1), .query_id_2(query_id_2),
    .query_ready_1(q_rdy1), .query_ready_2(q_rdy2),
    .query_value_1(q_val1), .query_value_2(q_val2),
    ._rob_commit_ready(commit_ready), ._rob_commit_rob_id(commit_rob_id),
    ._rob_commit_register_id(commit_reg_id), ._rob_commit_value(commit_value),
    .commit_store(commit_store), ._clear(clear), .redirect_pc(redirect_pc)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    int id;
    int kind;
    logic [4:0] rd;
    bit done;
    bit mp;
    logic [31:0] val;
    logic [31:0] alt;
  } ent_t;
  ent_t q[$];
  int tail_id;
  bit e_cr, e_cs, e_clr;
  logic [4:0] e_cid, e_crd;
  logic [31:0] e_cval, e_rpc;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit is_reg(input int k);
    return k == 0 || k == 3;
  endfunction

  task automatic model_reset();
    q.delete();
    tail_id = 1;
    {e_cr, e_cs, e_clr} = '0;
    e_cid = '0;
    e_crd = '0;
    e_cval = '0;
    e_rpc = '0;
  endtask

  task automatic model_query(input logic [4:0] id, output bit r, output logic [31:0] v);
    r = 0;
    v = '0;
    if (id != 0) begin
      foreach (q[i]) if (q[i].id == id && q[i].done) begin
        r = 1;
        v = q[i].val;
      end
      if (!r && wb_valid && wb_rob_id == id) begin
        r = 1;
        v = wb_value;
      end
    end
  endtask

  task automatic idle_inputs();
    rdy_in = 1'b1;
    issue_valid = 1'b0;
    wb_valid = 1'b0;
    wb_mispredict = 1'b0;
    query_id_1 = '0;
    query_id_2 = '0;
  endtask

  // one clock: check combinational outputs, advance the model, check registered outputs
  task automatic cycle();
    bit full, acc, ret, fl, r;
    logic [31:0] v;
    ent_t e;
    #2;
    full = q.size() == DEPTH;
    acc = rdy_in && issue_valid && !full && !e_clr;
    chk("issue_full", issue_full, full);
    chk("issue_rob_id", issue_rob_id, tail_id);
    chk("launch_ready", launch_ready, acc);
    chk("launch_rob_id", launch_rob_id, tail_id);
    chk("launch_reg_id", launch_reg_id, is_reg(int'(issue_kind)) ? issue_rd : 5'd0);
    model_query(query_id_1, r, v);
    chk("query_ready_1", q_rdy1, r);
    chk("query_value_1", q_val1, v);
    model_query(query_id_2, r, v);
    chk("query_ready_2", q_rdy2, r);
    chk("query_value_2", q_val2, v);
    if (rdy_in) begin
      ret = q.size() > 0 && q[0].done;
      fl = ret && q[0].kind == 2 && q[0].mp;
      e_cr = ret && is_reg(q[0].kind);
      e_cs = ret && q[0].kind == 1;
      if (e_cr) begin
        e_cid = 5'(q[0].id);
        e_crd = q[0].rd;
        e_cval = q[0].val;
      end
      if (fl) begin
        e_rpc = q[0].alt;
        q.delete();
        tail_id = 1;
      end else begin
        if (wb_valid && !e_clr)
          foreach (q[i]) if (q[i].id == int'(wb_rob_id)) begin
            q[i].done = 1;
            q[i].val = wb_value;
            q[i].mp = wb_mispredict;
          end
        if (ret) void'(q.pop_front());
        if (acc) begin
          e = '{id: tail_id, kind: int'(issue_kind), rd: issue_rd, done: 0, mp: 0, val: 0, alt: issue_alt_pc};
          q.push_back(e);
          tail_id = tail_id % DEPTH + 1;
        end
      end
      e_clr = fl;
    end
    @(posedge clk_in);
    #1;
    chk("commit_ready", commit_ready, e_cr);
    chk("commit_rob_id", commit_rob_id, e_cid);
    chk("commit_reg_id", commit_reg_id, e_crd);
    chk("commit_value", commit_value, e_cval);
    chk("commit_store", commit_store, e_cs);
    chk("clear", clear, e_clr);
    if (e_clr) chk("redirect_pc", redirect_pc, e_rpc);
  endtask

  task automatic issue(input int k, input int rd, input logic [31:0] alt);
    idle_inputs();
    issue_valid = 1'b1;
    issue_kind = 2'(k);
    issue_rd = 5'(rd);
    issue_alt_pc = alt;
    cycle();
  endtask

  task automatic wb(input int id, input logic [31:0] v, input bit mp);
    idle_inputs();
    wb_valid = 1'b1;
    wb_rob_id = 5'(id);
    wb_value = v;
    wb_mispredict = mp;
    query_id_1 = 5'(id);
    cycle();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      idle_inputs();
      cycle();
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_commit_ready"}, commit_ready, 0);
    chk({tag, "_commit_rob_id"}, commit_rob_id, 0);
    chk({tag, "_commit_value"}, commit_value, 0);
    chk({tag, "_commit_store"}, commit_store, 0);
    chk({tag, "_clear"}, clear, 0);
    chk({tag, "_redirect_pc"}, redirect_pc, 0);
    chk({tag, "_issue_full"}, issue_full, 0);
    chk({tag, "_issue_rob_id"}, issue_rob_id, 1);
  endtask

  task automatic rand_cycle(input int p_issue, input int p_wb);
    int k;
    rdy_in = $urandom_range(0, 99) >= 8;
    issue_valid = $urandom_range(0, 99) < p_issue;
    k = $urandom_range(0, 99);
    issue_kind = (k < 65) ? 2'd0 : (k < 78) ? 2'd1 : (k < 93) ? 2'd2 : 2'd3;
    issue_rd = 5'($urandom);
    issue_alt_pc = $urandom;
    wb_valid = $urandom_range(0, 99) < p_wb;
    wb_rob_id = (q.size() > 0 && $urandom_range(0, 9) != 0) ?
                5'(q[$urandom_range(0, q.size() - 1)].id) : 5'($urandom_range(0, 31));
    wb_value = $urandom;
    wb_mispredict = $urandom_range(0, 99) < 12;
    query_id_1 = (q.size() > 0 && $urandom_range(0, 3) != 0) ?
                 5'(q[$urandom_range(0, q.size() - 1)].id) : 5'($urandom_range(0, DEPTH));
    query_id_2 = $urandom_range(0, 1) ? wb_rob_id : 5'($urandom_range(0, DEPTH));
    if (query_id_2 > DEPTH) query_id_2 = '0;
    cycle();
  endtask

  initial begin
    model_reset();
    #1;
    check_reset_outputs("reset");
    @(posedge clk_in);
    #1;
    rst_n_in = 1'b1;
    // basic issue, writeback, commit
    issue(0, 5, 32'h0);
    wb(1, 32'h1234, 0);
    idle(2);
    // fill to full, then one held issue, then free a slot
    for (int i = 0; i < DEPTH + 1; i++) issue(0, i + 1, 32'h0);
    wb(q[0].id, 32'hbeef, 0);
    issue(0, 9, 32'h0);
    issue(0, 9, 32'h0);
    issue(0, 9, 32'h0);
    for (int i = 0; i < DEPTH; i++) wb(q[i].id, 32'h100 + i, 0);
    idle(DEPTH + 2);
    // out-of-order completion with query while pending
    for (int i = 0; i < 3; i++) issue(0, 7 + i, 32'h0);
    wb(q[2].id, 32'h33, 0);
    wb(q[1].id, 32'h22, 0);
    wb(q[0].id, 32'h11, 0);
    idle(4);
    // mispredicted branch with younger completed entries
    model_reset();
    rst_n_in = 1'b0;
    #1;
    rst_n_in = 1'b1;
    issue(2, 0, 32'h200);
    issue(0, 3, 32'h0);
    issue(0, 4, 32'h0);
    wb(2, 32'haa, 0);
    wb(3, 32'hbb, 0);
    wb(1, 32'h0, 1);
    idle(3);
    // randomized phases
    for (int n = 0; n < 3000; n++)
      rand_cycle((n / 500) % 2 ? 80 : 45, (n / 500) % 3 == 1 ? 20 : 60);
    // asynchronous reset with entries in flight
    for (int i = 0; i < 5; i++) issue(0, i + 1, 32'h0);
    wb(q[0].id, 32'h55, 0);
    idle_inputs();
    #3;
    rst_n_in = 1'b0;
    #1;
    check_reset_outputs("async_reset");
    model_reset();
    @(posedge clk_in);
    #1;
    rst_n_in = 1'b1;
    for (int n = 0; n < 1500; n++) rand_cycle(60, 50);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
